// File: rtl/svc_uart_pkg.sv
// Shared UART definitions: receiver state encoding, cycles-per-bit helper and data width.
package svc_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } uart_rx_state_t;

  function automatic int uart_cpb(input int freq_mhz, input int baud);
    return (freq_mhz * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/svc_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RST_VAL.
module svc_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/svc_uart_rx.sv
// UART receiver, 8N1 with one-entry valid/ready output register and error pulses.
// Define SVC_UART_RX_PARITY_EN for 8E1 frames with even-parity checking.
//
// state     | meaning
// RX_IDLE   | line idle, waiting for rx_s low
// RX_START  | half-bit wait, start bit re-check (glitch filter)
// RX_DATA   | sampling 8 data bits, LSB first
// RX_PARITY | sampling even-parity bit (parity build only)
// RX_STOP   | sampling stop bit, then deliver or flag
module svc_uart_rx
  import svc_uart_pkg::*;
#(
  parameter int CLOCK_FREQ_MHZ = 25,
  parameter int BAUD_RATE      = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       urx_valid,
  output logic [7:0] urx_data,
  input  logic       urx_ready,
  output logic       urx_frame_err,
  output logic       urx_parity_err,
  output logic       urx_overrun
);

  localparam int CPB  = uart_cpb(CLOCK_FREQ_MHZ, BAUD_RATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [2:0]    LAST_IDX = 3'(UART_DATA_BITS - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("svc_uart_rx: clock/baud ratio below 4 cycles per bit");
    end
  endgenerate

  logic rx_s;

  svc_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (uart_rx),
    .q_o (rx_s)
  );

  uart_rx_state_t  state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            deliver;
`ifdef SVC_UART_RX_PARITY_EN
  logic            par_err_q, par_err_d;
  logic            parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    valid_d     = valid_q;
    data_d      = data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;
`ifdef SVC_UART_RX_PARITY_EN
    par_err_d    = par_err_q;
    parity_err_d = 1'b0;
`endif

    if (valid_q && urx_ready) valid_d = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          cnt_d   = CNT_HALF;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s) begin
          state_d = RX_IDLE;
        end else begin
          cnt_d   = CNT_FULL;
          idx_d   = 3'd0;
          state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shreg_d[idx_q] = rx_s;
          cnt_d          = CNT_FULL;
          idx_d          = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
`ifdef SVC_UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef SVC_UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          par_err_d = (^shreg_q) ^ rx_s;
          cnt_d     = CNT_FULL;
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught in time.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = RX_IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end
`ifdef SVC_UART_RX_PARITY_EN
          else if (par_err_q) begin
            parity_err_d = 1'b1;
          end
`endif
          else begin
            deliver = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (deliver) begin
      if (!valid_q || urx_ready) begin
        valid_d = 1'b1;
        data_d  = shreg_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shreg_q     <= 8'h00;
      valid_q     <= 1'b0;
      data_q      <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SVC_UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign urx_parity_err = parity_err_q;
`else
  assign urx_parity_err = 1'b0;
`endif

  assign urx_valid     = valid_q;
  assign urx_data      = data_q;
  assign urx_frame_err = frame_err_q;
  assign urx_overrun   = overrun_q;

endmodule

// File: tb/tb_svc_uart_rx.sv
// Scoreboard bench for svc_uart_rx at CPB=10: latency, back-to-back, glitch, framing, overrun, reset.
module tb_svc_uart_rx;
  import svc_uart_pkg::*;

  localparam int CPB = 10;
`ifdef SVC_UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int LAT = NBITS * CPB - 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       urx_ready = 1'b0;
  logic       urx_valid;
  logic [7:0] urx_data;
  logic       urx_frame_err;
  logic       urx_parity_err;
  logic       urx_overrun;

  svc_uart_rx #(.CLOCK_FREQ_MHZ(1), .BAUD_RATE(100_000)) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rx        (uart_rx),
    .urx_valid      (urx_valid),
    .urx_data       (urx_data),
    .urx_ready      (urx_ready),
    .urx_frame_err  (urx_frame_err),
    .urx_parity_err (urx_parity_err),
    .urx_overrun    (urx_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int n_ferr, n_perr, n_ovr, n_valid;
  int first_valid_cyc = -1;
  int ovr_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (urx_frame_err)  n_ferr++;
      if (urx_parity_err) n_perr++;
      if (urx_overrun) begin
        n_ovr++;
        ovr_cyc = cyc;
      end
      if (urx_valid) begin
        n_valid++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (urx_valid && urx_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_byte", sb.size(), 1);
        end else begin
          exp_b = sb.pop_front();
          chk("rx_data", {24'd0, urx_data}, {24'd0, exp_b});
        end
      end
    end
  end

  task automatic clr_mon();
    n_ferr = 0; n_perr = 0; n_ovr = 0; n_valid = 0;
    first_valid_cyc = -1;
    ovr_cyc = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    tick(CPB);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef SVC_UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit !== (^b)) $display("note: parity argument ignored in 8N1 build");
`endif
    drive_bit(stop_bit);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_raw(b, ^b, stop_bit);
  endtask

  int st;

  initial begin
    clr_mon();
    rst = 1'b1;
    tick(5);
    chk("rst_valid", urx_valid, 0);
    chk("rst_data", urx_data, 0);
    chk("rst_ferr", urx_frame_err, 0);
    chk("rst_perr", urx_parity_err, 0);
    chk("rst_ovr", urx_overrun, 0);
    chk("rst_state", dut.state_q, RX_IDLE);
    rst = 1'b0;
    tick(5);

    // single byte: latency from line fall to visible valid
    urx_ready = 1'b1;
    clr_mon();
    sb.push_back(8'hA5);
    st = cyc;
    send_frame(8'hA5, 1'b1);
    tick(20);
    chk("a5_latency", first_valid_cyc - st, LAT);
    chk("a5_valid_cycles", n_valid, 1);
    chk("a5_flags", n_ferr + n_perr + n_ovr, 0);

    // back-to-back frames
    clr_mon();
    sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'h55);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    tick(20);
    chk("b2b_count", n_valid, 3);
    chk("b2b_flags", n_ferr + n_perr + n_ovr, 0);
    chk("b2b_sb_empty", sb.size(), 0);

    // short low glitch
    clr_mon();
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(20);
    chk("glitch_valid", n_valid, 0);
    chk("glitch_flags", n_ferr + n_perr + n_ovr, 0);
    chk("glitch_state", dut.state_q, RX_IDLE);

    // stop bit low
    clr_mon();
    send_frame(8'h3C, 1'b0);
    tick(30);
    chk("ferr_count", n_ferr, 1);
    chk("ferr_valid", n_valid, 0);
    chk("ferr_state", dut.state_q, RX_IDLE);

    // overrun: held byte kept, second dropped
    urx_ready = 1'b0;
    clr_mon();
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    st = cyc;
    send_frame(8'h22, 1'b1);
    tick(10);
    chk("ovr_count", n_ovr, 1);
    chk("ovr_cycle", ovr_cyc - st, LAT);
    chk("ovr_held_data", urx_data, 8'h11);
    chk("ovr_held_valid", urx_valid, 1);
    urx_ready = 1'b1;
    tick(1);
    urx_ready = 1'b0;
    tick(3);
    chk("ovr_sb_empty", sb.size(), 0);
    chk("ovr_drained", urx_valid, 0);

    // consume on the delivery cycle: no overrun
    clr_mon();
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    sb.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        tick(LAT - 1);
        urx_ready = 1'b1;
        tick(1);
        urx_ready = 1'b0;
      end
    join
    tick(5);
    chk("simul_ovr", n_ovr, 0);
    chk("simul_data", urx_data, 8'h22);
    chk("simul_valid", urx_valid, 1);
    urx_ready = 1'b1;
    tick(2);
    chk("simul_sb_empty", sb.size(), 0);

`ifdef SVC_UART_RX_PARITY_EN
    clr_mon();
    send_raw(8'h07, 1'b0, 1'b1);
    tick(20);
    chk("par_err_count", n_perr, 1);
    chk("par_err_valid", n_valid, 0);
    clr_mon();
    sb.push_back(8'h07);
    send_raw(8'h07, 1'b1, 1'b1);
    tick(20);
    chk("par_ok_valid", n_valid, 1);
    chk("par_ok_perr", n_perr, 0);
`endif

    // reset mid-DATA discards held byte
    urx_ready = 1'b0;
    clr_mon();
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(10);
    chk("pre_rst_valid", urx_valid, 1);
    uart_rx = 1'b0;
    tick(35);
    rst = 1'b1;
    tick(2);
    chk("mid_rst_valid", urx_valid, 0);
    chk("mid_rst_data", urx_data, 0);
    chk("mid_rst_state", dut.state_q, RX_IDLE);
    uart_rx = 1'b1;
    sb.delete();
    rst = 1'b0;
    tick(20);
    chk("post_rst_valid", urx_valid, 0);
    chk("post_rst_flags", urx_frame_err | urx_parity_err | urx_overrun, 0);
    urx_ready = 1'b1;
    clr_mon();
    sb.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    tick(20);
    chk("post_rst_rx", n_valid, 1);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/svc_uart_rx.md
# svc_uart_rx

UART receiver, 8N1 (optional even parity), for the SoC's serial console path. It is the far end of the `uart_tx` line driven by the SoC. Simulation benches and host-loopback designs use it to recover transmitted bytes. Received bytes are presented on a one-entry valid/ready output register, and framing, parity and overrun events are flagged.

## Interface
- `CLOCK_FREQ_MHZ`, 25, system clock frequency in MHz
- `BAUD_RATE`, 115_200, line rate in bits/s
- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `uart_rx`  input  1  asynchronous serial line, idle high
- `urx_valid`  output  1  byte held in output register
- `urx_data`  output  8  received byte, LSB first on the line
- `urx_ready`  input  1  consumer accepts byte when `urx_valid && urx_ready`
- `urx_frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `urx_parity_err`  output  1  one-cycle pulse: parity mismatch (0 when parity is compiled out)
- `urx_overrun`  output  1  one-cycle pulse: new byte dropped because the register was full

## Operation
- Arithmetic: `CPB = (CLOCK_FREQ_MHZ*1_000_000)/BAUD_RATE` (floor) and `HALF = CPB/2`. The bit counter is `$clog2(CPB)` bits wide. `CPB >= 4` is enforced by an elaboration-time assertion.
- `uart_rx` passes through a 2-flop synchronizer (reset value 1). All decoding uses the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when `rx_s == 0`, load counter with `HALF-1` and go to START.
- START: at counter 0, sample `rx_s`.
  - If 1 (glitch), return to IDLE with no flags raised.
  - Otherwise reload `CPB-1` and enter DATA with bit index 0.
- DATA: at each counter 0, shift `rx_s` into bit[index] and reload `CPB-1`. After index 7, go to PARITY (macro defined) or STOP.
- PARITY: sample at counter 0. Error if `^data ^ rx_s != 0` (even parity). Reload `CPB-1` and go to STOP.
- STOP: sample at counter 0, then return to IDLE immediately. Returning at mid-stop-bit allows back-to-back frames.
  - Stop = 0: pulse `urx_frame_err` and discard the byte.
  - Parity error: pulse `urx_parity_err` and discard the byte.
  - Otherwise deliver the byte.
- Delivery rules:
  - If the output register is empty, or is being consumed this cycle (`urx_valid && urx_ready`), load `urx_data` and set `urx_valid`. No overrun is flagged in the simultaneous case.
  - Else drop the new byte, keep the held byte, and pulse `urx_overrun`.
- `urx_valid` clears on the handshake when nothing new loads in the same cycle.
- `urx_data` is stable while `urx_valid` is high.
- Reset values: `urx_valid`=0, `urx_data`=0, all error pulses 0, FSM in IDLE, synchronizer 1.
- `rst` mid-frame aborts the frame and discards the held byte. After reset, the next falling edge starts a new frame.

## Timing
- Let T0 be the first edge at which `rx_s == 0`. T0 is 2 cycles after the raw line falls.
- Sample k occurs at edge T0 + HALF + k·CPB.
  - k = 0: start bit.
  - k = 1..8: data bits.
  - k = 9: stop bit, or parity when the macro is defined (stop then at k = 10).
- `urx_valid` and the error pulses are registered at the stop sample. They are visible the following cycle.
- Once the stop sample completes, the next falling edge is detected within 1 cycle.

## Configuration
- `SVC_UART_RX_PARITY_EN`, defined: a PARITY state follows DATA, and frames are 11 bits (8E1). A mismatch drops the byte and pulses `urx_parity_err`.
- Undefined: no PARITY state, frames are 10 bits (8N1), and `urx_parity_err` is tied 0.

## Structure
- Package `svc_uart_pkg` contains:
  - the state enum `uart_rx_state_t`;
  - a function `uart_cpb(freq_mhz, baud)` returning CPB, shared with the transmitter;
  - the constant `UART_DATA_BITS = 8`.
- Sub-module `svc_sync2` is the 2-flop synchronizer for `uart_rx`.

## Test plan
All scenarios use `CLOCK_FREQ_MHZ=1`, `BAUD_RATE=100_000` (CPB=10, HALF=5), with parity off unless stated.
- Send 0xA5 with `urx_ready` held 1 → `urx_valid` high 1 cycle with `urx_data=0xA5`, exactly 2+5+90+1 cycles after the line falls.
- Send 0x00, 0xFF, 0x55 back-to-back with stop bits of exactly CPB → all three bytes received in order, no flags.
- 3-cycle low glitch on an idle line → no `urx_valid`, no flags, FSM returns to IDLE.
- Send 0x3C with the stop bit forced low → `urx_frame_err` pulses once, `urx_valid` stays 0.
- `urx_ready`=0, send 0x11 then 0x22 → `urx_data` stays 0x11 and `urx_overrun` pulses at the second stop sample. Repeat with `urx_ready` raised on the delivery cycle → 0x22 loads with no overrun.
- With `SVC_UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `urx_parity_err` pulses. Send it with parity bit 1 → byte delivered. Assert `rst` mid-DATA → outputs return to reset values.
